// File: rtl/tl_phase_scheduler_pkg.sv
// rtl/tl_phase_scheduler_pkg.sv - light codes and state encoding for the phase scheduler
//
// Package tl_pkg: shared constants for tl_phase_scheduler and its helpers.
//   Light codes : GREEN, YELLOW, LEFT, RED (2 bits)
//   States      : AG..PRE (4 bits, fixed encoding, also the debug phase value)
package tl_pkg;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] LEFT   = 2'b10;
    localparam logic [1:0] RED    = 2'b11;

    localparam logic [3:0] AG  = 4'd0;
    localparam logic [3:0] AY  = 4'd1;
    localparam logic [3:0] AL  = 4'd2;
    localparam logic [3:0] ALY = 4'd3;
    localparam logic [3:0] BG  = 4'd4;
    localparam logic [3:0] BY  = 4'd5;
    localparam logic [3:0] BL  = 4'd6;
    localparam logic [3:0] BLY = 4'd7;
    localparam logic [3:0] PED = 4'd8;
    localparam logic [3:0] PRE = 4'd9;

    // Green/left exit: sensor gone after the minimum, or the maximum reached.
    function automatic logic green_done(input logic sensor, input logic at_min, input logic at_max);
        return at_max || (at_min && !sensor);
    endfunction

endpackage

// File: rtl/tl_phase_scheduler_if.sv
// rtl/tl_phase_scheduler_if.sv - sensor/request inputs and light outputs of the scheduler
//
// Signals:
//   Ta, Tb, Tal, Tbl : vehicle sensors (straight A/B, left A/B)
//   ped_req          : pedestrian button pulse
//   emerg            : emergency preempt level
//   La, Lb           : light codes for approach A / B
//   walk             : walk lamp
//   phase            : current state encoding (debug)
// Modports: master drives the requests and observes the lights; slave is the scheduler.
interface tl_phase_scheduler_if;
    logic       Ta;
    logic       Tb;
    logic       Tal;
    logic       Tbl;
    logic       ped_req;
    logic       emerg;
    logic [1:0] La;
    logic [1:0] Lb;
    logic       walk;
    logic [3:0] phase;

    modport master (
        output Ta, Tb, Tal, Tbl, ped_req, emerg,
        input  La, Lb, walk, phase
    );

    modport slave (
        input  Ta, Tb, Tal, Tbl, ped_req, emerg,
        output La, Lb, walk, phase
    );
endinterface

// File: rtl/tl_phase_scheduler_timer.sv
// rtl/tl_phase_scheduler_timer.sv - saturating phase timer, cleared on state change
//
// Module tl_phase_timer.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, timer to 0
//   clr   : the state changes at this edge; timer restarts at 0
//   cnt   : cycles spent in the current state, saturates at all-ones
module tl_phase_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tl_phase_scheduler.sv
// rtl/tl_phase_scheduler.sv - timed A/B phase scheduler with left turns, walk and preempt
//
// Module tl_phase_scheduler.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (state AG, flags cleared)
//   bus   : tl_phase_scheduler_if.slave - sensors, ped_req, emerg in; La, Lb, walk, phase out
// Parameters: MIN_GREEN, MAX_GREEN, YELLOW, WALK (cycles), CNT_W (timer width).
module tl_phase_scheduler #(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 16,
    parameter int YELLOW    = 2,
    parameter int WALK      = 6,
    parameter int CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    tl_phase_scheduler_if.slave  bus
);
    import tl_pkg::*;

    localparam logic [CNT_W-1:0] MIN_M1  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_M1  = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] WALK_M1 = CNT_W'(WALK - 1);

    logic [3:0]       state;
    logic [3:0]       state_nx;
    logic [CNT_W-1:0] timer;
    logic             ped_pend;
    logic             next_b;
    logic             next_b_nx;
    logic             at_min;
    logic             at_max;
    logic             yel_done;
    logic             enter_ped;

    assign at_min   = (timer >= MIN_M1);
    assign at_max   = (timer == MAX_M1);
    assign yel_done = (timer == YEL_M1);

    tl_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (state_nx != state),
        .cnt   (timer)
    );

    // Next-state logic. End of a side either hands over to the other
    // side's green or diverts to PED, remembering where PED must return.
    always_comb begin
        state_nx  = state;
        next_b_nx = next_b;
        case (state)
            AG: begin
                if (bus.emerg || green_done(bus.Ta, at_min, at_max)) state_nx = AY;
            end
            AL: begin
                if (bus.emerg || green_done(bus.Tal, at_min, at_max)) state_nx = ALY;
            end
            BG: begin
                if (bus.emerg || green_done(bus.Tb, at_min, at_max)) state_nx = BY;
            end
            BL: begin
                if (bus.emerg || green_done(bus.Tbl, at_min, at_max)) state_nx = BLY;
            end
            AY, ALY: begin
                if (yel_done) begin
                    if (bus.emerg) begin
                        state_nx = PRE;
                    end else if (state == AY && bus.Tal) begin
                        state_nx = AL;
                    end else if (ped_pend) begin
                        state_nx  = PED;
                        next_b_nx = 1'b1;
                    end else begin
                        state_nx = BG;
                    end
                end
            end
            BY, BLY: begin
                if (yel_done) begin
                    if (bus.emerg) begin
                        state_nx = PRE;
                    end else if (state == BY && bus.Tbl) begin
                        state_nx = BL;
                    end else if (ped_pend) begin
                        state_nx  = PED;
                        next_b_nx = 1'b0;
                    end else begin
                        state_nx = AG;
                    end
                end
            end
            PED: begin
                if (bus.emerg) begin
                    state_nx = PRE;
                end else if (timer == WALK_M1) begin
                    state_nx = next_b ? BG : AG;
                end
            end
            PRE: begin
                if (!bus.emerg) state_nx = AG;
            end
            default: state_nx = AG;
        endcase
    end

    assign enter_ped = (state_nx == PED) && (state != PED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= AG;
            ped_pend <= 1'b0;
            next_b   <= 1'b0;
        end else begin
            state  <= state_nx;
            next_b <= next_b_nx;
            // A press on the PED entry edge wins, so that walk is served again.
            if (bus.ped_req) begin
                ped_pend <= 1'b1;
            end else if (enter_ped) begin
                ped_pend <= 1'b0;
            end
        end
    end

    // Moore output decode.
    always_comb begin
        bus.La   = RED;
        bus.Lb   = RED;
        bus.walk = 1'b0;
        case (state)
            AG:      bus.La = GREEN;
            AY, ALY: bus.La = tl_pkg::YELLOW;
            AL:      bus.La = LEFT;
            BG:      bus.Lb = GREEN;
            BY, BLY: bus.Lb = tl_pkg::YELLOW;
            BL:      bus.Lb = LEFT;
            PED:     bus.walk = 1'b1;
            default: ;
        endcase
    end

    assign bus.phase = state;

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// tb/tb_tl_phase_scheduler.sv - directed table-driven bench for tl_phase_scheduler
`timescale 1ns/1ps
module tb_tl_phase_scheduler;

    localparam logic [3:0] S_AG = 4'd0, S_AY = 4'd1, S_AL = 4'd2, S_ALY = 4'd3;
    localparam logic [3:0] S_BG = 4'd4, S_BY = 4'd5, S_BL = 4'd6, S_BLY = 4'd7;
    localparam logic [3:0] S_PED = 4'd8, S_PRE = 4'd9;

    typedef struct {
        logic [5:0] ins;   // {Ta, Tb, Tal, Tbl, ped_req, emerg}
        logic [3:0] ph;
        logic [1:0] la;
        logic [1:0] lb;
        logic       wk;
        int         n;
    } seg_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    seg_t segs[$];

    tl_phase_scheduler_if bus ();

    tl_phase_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [5:0] ins);
        bus.Ta      = ins[5];
        bus.Tb      = ins[4];
        bus.Tal     = ins[3];
        bus.Tbl     = ins[2];
        bus.ped_req = ins[1];
        bus.emerg   = ins[0];
    endtask

    task automatic check(input string name, input logic [3:0] ph, input logic [1:0] la,
                         input logic [1:0] lb, input logic wk);
        checks++;
        if (bus.phase !== ph || bus.La !== la || bus.Lb !== lb || bus.walk !== wk) begin
            errors++;
            $display("FAIL %s: phase=%0d La=%b Lb=%b walk=%b, required phase=%0d La=%b Lb=%b walk=%b",
                     name, bus.phase, bus.La, bus.Lb, bus.walk, ph, la, lb, wk);
        end
    endtask

    task automatic add(input logic [5:0] ins, input logic [3:0] ph, input logic [1:0] la,
                       input logic [1:0] lb, input logic wk, input int n);
        seg_t s;
        s.ins = ins; s.ph = ph; s.la = la; s.lb = lb; s.wk = wk; s.n = n;
        segs.push_back(s);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(6'b000000);
        reset = 1'b1;

        // Ta=1 only: AG runs to max, AL skipped, BG at min.
        add(6'b100000, S_AG,  2'b00, 2'b11, 1'b0, 16);
        add(6'b100000, S_AY,  2'b01, 2'b11, 1'b0, 2);
        add(6'b100000, S_BG,  2'b11, 2'b00, 1'b0, 4);
        add(6'b100000, S_BY,  2'b11, 2'b01, 1'b0, 2);
        // Left turn on A: AG min, Tal seen at yellow end, AL held then released.
        add(6'b000000, S_AG,  2'b00, 2'b11, 1'b0, 4);
        add(6'b001000, S_AY,  2'b01, 2'b11, 1'b0, 2);
        add(6'b001000, S_AL,  2'b10, 2'b11, 1'b0, 6);
        add(6'b000000, S_AL,  2'b10, 2'b11, 1'b0, 1);
        add(6'b000000, S_ALY, 2'b01, 2'b11, 1'b0, 2);
        // One-cycle ped press in BG: PED after BY, then AG.
        add(6'b000010, S_BG,  2'b11, 2'b00, 1'b0, 1);
        add(6'b000000, S_BG,  2'b11, 2'b00, 1'b0, 3);
        add(6'b000000, S_BY,  2'b11, 2'b01, 1'b0, 2);
        add(6'b000000, S_PED, 2'b11, 2'b11, 1'b1, 6);
        // Pending walk consumed: the next A end goes straight to BG.
        add(6'b000000, S_AG,  2'b00, 2'b11, 1'b0, 4);
        add(6'b000000, S_AY,  2'b01, 2'b11, 1'b0, 2);
        add(6'b000000, S_BG,  2'b11, 2'b00, 1'b0, 4);
        add(6'b000000, S_BY,  2'b11, 2'b01, 1'b0, 2);
        // Preempt on 2nd AG cycle: yellow at once, full yellow, PRE, release to AG.
        add(6'b100000, S_AG,  2'b00, 2'b11, 1'b0, 1);
        add(6'b100001, S_AG,  2'b00, 2'b11, 1'b0, 1);
        add(6'b101001, S_AY,  2'b01, 2'b11, 1'b0, 2);
        add(6'b000001, S_PRE, 2'b11, 2'b11, 1'b0, 5);
        add(6'b000000, S_PRE, 2'b11, 2'b11, 1'b0, 1);
        // Timer restarted at 0: AG lasts exactly the minimum.
        add(6'b000000, S_AG,  2'b00, 2'b11, 1'b0, 4);
        add(6'b000000, S_AY,  2'b01, 2'b11, 1'b0, 2);
        // Preempt during PED.
        add(6'b000010, S_BG,  2'b11, 2'b00, 1'b0, 1);
        add(6'b000000, S_BG,  2'b11, 2'b00, 1'b0, 3);
        add(6'b000000, S_BY,  2'b11, 2'b01, 1'b0, 2);
        add(6'b000000, S_PED, 2'b11, 2'b11, 1'b1, 2);
        add(6'b000001, S_PED, 2'b11, 2'b11, 1'b1, 1);
        add(6'b000000, S_PRE, 2'b11, 2'b11, 1'b0, 1);
        // Press on the PED entry edge: a second PED at the following end of side.
        add(6'b000010, S_AG,  2'b00, 2'b11, 1'b0, 1);
        add(6'b000000, S_AG,  2'b00, 2'b11, 1'b0, 3);
        add(6'b000000, S_AY,  2'b01, 2'b11, 1'b0, 1);
        add(6'b000010, S_AY,  2'b01, 2'b11, 1'b0, 1);
        add(6'b000000, S_PED, 2'b11, 2'b11, 1'b1, 6);
        add(6'b000000, S_BG,  2'b11, 2'b00, 1'b0, 4);
        add(6'b000000, S_BY,  2'b11, 2'b01, 1'b0, 2);
        add(6'b000000, S_PED, 2'b11, 2'b11, 1'b1, 6);
        // Into BL for the reset test.
        add(6'b000000, S_AG,  2'b00, 2'b11, 1'b0, 4);
        add(6'b000000, S_AY,  2'b01, 2'b11, 1'b0, 2);
        add(6'b000100, S_BG,  2'b11, 2'b00, 1'b0, 4);
        add(6'b000100, S_BY,  2'b11, 2'b01, 1'b0, 2);
        add(6'b000100, S_BL,  2'b11, 2'b10, 1'b0, 3);

        repeat (2) @(posedge clk);
        #1;
        check("reset", S_AG, 2'b00, 2'b11, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < segs.size(); i++) begin
            for (int k = 0; k < segs[i].n; k++) begin
                drive(segs[i].ins);
                check($sformatf("seg%0d_cyc%0d", i, k), segs[i].ph, segs[i].la, segs[i].lb, segs[i].wk);
                @(posedge clk);
                #1;
            end
        end

        // Mid-BL asynchronous reset: lights go to AG between clock edges.
        check("bl_before_reset", S_BL, 2'b11, 2'b10, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_mid_bl", S_AG, 2'b00, 2'b11, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held", S_AG, 2'b00, 2'b11, 1'b0);
        reset = 1'b0;
        drive(6'b000000);
        // Walk lost on reset and timer restarted: AG min, AY, then BG.
        for (int k = 0; k < 4; k++) begin
            check("post_reset_ag", S_AG, 2'b00, 2'b11, 1'b0);
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 2; k++) begin
            check("post_reset_ay", S_AY, 2'b01, 2'b11, 1'b0);
            @(posedge clk);
            #1;
        end
        check("post_reset_bg", S_BG, 2'b11, 2'b00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
